adc_serial_responder: RTL and testbench

//   Synthesizable slave end of the detector ADC serial link: answers adc_cs/adc_clk from the tag's ADC reader

---
 rtl/adc_serial_responder.sv | 170 +++++++++++++++++
 tb/tb_adc_serial_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_responder.sv
// Serial-ADC slave stand-in: answers adc_cs/adc_clk with a zero-padded, MSB-first sample frame.
// Pin inputs are oversampled on clk and synchronized; all actions are taken on synced edges.
module adc_serial_responder #(
  parameter int ZERO_BITS   = 3,
  parameter int DATA_BITS   = 8,
  parameter int TRAIL_BITS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_cs,
  input  logic                 adc_clk,
  output logic                 adc_so,
  output logic                 adc_so_oe,
  input  logic [DATA_BITS-1:0] sample_in,
  output logic                 conv_start,
  output logic                 conv_done,
  output logic                 frame_err,
  output logic [15:0]          frame_count
);

  // state | meaning
  // IDLE  | no frame; adc_so=0, oe=0, waiting for synced cs falling edge
  // SHIFT | frame active; each synced adc_clk fall advances one bit
  // DONE  | all bits sent; drive 0 until cs released

  localparam int N  = ZERO_BITS + DATA_BITS + TRAIL_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] N_LAST = CW'(N);
  localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_n;
  logic [N-1:0]         shreg, shreg_n;
  logic [CW-1:0]        bitcnt, bitcnt_n;
  logic                 so_n, oe_n, start_n, done_n, err_n;
  logic [15:0]          count_n;

  logic [SYNC_STAGES-1:0] cs_sync, clk_sync;
  logic                   cs_d, clk_d;
  logic                   cs_s, clk_s;
  logic [SW-1:0]          settle_cnt;
  logic                   armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync  <= '1;
      clk_sync <= '1;
      cs_d     <= 1'b1;
      clk_d    <= 1'b1;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], adc_clk};
      cs_d     <= cs_s;
      clk_d    <= clk_s;
    end
  end

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];

  // A cs held low through reset must not start a frame: only arm once the
  // chain has flushed and cs has actually been seen high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= SETTLE;
      armed      <= 1'b0;
    end else if (settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end else if (cs_s) begin
      armed <= 1'b1;
    end
  end

  logic          cs_fall, cs_rise, clk_fall;
  logic [N-1:0]  load_val, shifted;
  logic [CW-1:0] bitcnt_inc;

  assign cs_fall    = armed & cs_d & ~cs_s;
  assign cs_rise    = ~cs_d & cs_s;
  assign clk_fall   = clk_d & ~clk_s & ~cs_s;
  assign load_val   = N'(sample_in) << TRAIL_BITS;
  assign shifted    = shreg << 1;
  assign bitcnt_inc = bitcnt + 1'b1;

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    so_n     = adc_so;
    oe_n     = adc_so_oe;
    start_n  = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    count_n  = frame_count;
    case (state)
      IDLE: begin
        so_n = 1'b0;
        oe_n = 1'b0;
        if (cs_fall) begin
          shreg_n  = load_val;
          bitcnt_n = '0;
          start_n  = 1'b1;
          oe_n     = 1'b1;
          so_n     = load_val[N-1];
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        // cs release wins over a coincident clock fall
        if (cs_rise) begin
          err_n   = 1'b1;
          oe_n    = 1'b0;
          so_n    = 1'b0;
          state_n = IDLE;
        end else if (clk_fall) begin
          shreg_n  = shifted;
          bitcnt_n = bitcnt_inc;
          if (bitcnt_inc == N_LAST) begin
            so_n    = 1'b0;
            done_n  = 1'b1;
            count_n = frame_count + 16'd1;
            state_n = DONE;
          end else begin
            so_n = shifted[N-1];
          end
        end
      end
      DONE: begin
        so_n = 1'b0;
        if (cs_rise) begin
          oe_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        so_n    = 1'b0;
        oe_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      adc_so      <= 1'b0;
      adc_so_oe   <= 1'b0;
      conv_start  <= 1'b0;
      conv_done   <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bitcnt      <= bitcnt_n;
      adc_so      <= so_n;
      adc_so_oe   <= oe_n;
      conv_start  <= start_n;
      conv_done   <= done_n;
      frame_err   <= err_n;
      frame_count <= count_n;
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: drives reader-side cs/clk waveforms and
// checks captured frames, pulses, counters and reset behaviour against hand values.
module tb_adc_serial_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_cs, adc_clk;
  logic        adc_so, adc_so_oe;
  logic [7:0]  sample_in;
  logic        conv_start, conv_done, frame_err;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0, n_done = 0, n_err = 0;
  int b_start, b_done, b_err;
  logic [14:0] bits;

  adc_serial_responder dut (
    .clk(clk), .reset(reset), .adc_cs(adc_cs), .adc_clk(adc_clk),
    .adc_so(adc_so), .adc_so_oe(adc_so_oe), .sample_in(sample_in),
    .conv_start(conv_start), .conv_done(conv_done), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (conv_start) n_start++;
    if (conv_done)  n_done++;
    if (frame_err)  n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] s);
    sample_in = s;
    adc_cs    = 1'b0;
    tick(4);
  endtask

  // bit 0 is sampled before the first fall; bit k after fall k (4 clk per phase)
  task automatic shift_bits(input int nf, output logic [14:0] b);
    b = '0;
    b = {b[13:0], adc_so};
    for (int k = 1; k <= nf; k++) begin
      adc_clk = 1'b0;
      tick(4);
      adc_clk = 1'b1;
      tick(4);
      if (k < 15) b = {b[13:0], adc_so};
    end
  endtask

  task automatic snap();
    b_start = n_start;
    b_done  = n_done;
    b_err   = n_err;
  endtask

  initial begin
    reset = 1'b1; adc_cs = 1'b1; adc_clk = 1'b1; sample_in = 8'h00;
    tick(3);
    check("rst_so", {31'd0, adc_so}, 0);
    check("rst_oe", {31'd0, adc_so_oe}, 0);
    check("rst_count", {16'd0, frame_count}, 0);
    check("rst_pulses", {29'd0, conv_start, conv_done, frame_err}, 0);
    reset = 1'b0;
    tick(6);

    // 1: full frame with A5, latency on both cs edges
    snap();
    sample_in = 8'hA5; adc_cs = 1'b0;
    tick(2);
    check("t1_oe_lat2", {31'd0, adc_so_oe}, 0);
    tick(1);
    check("t1_oe_lat3", {31'd0, adc_so_oe}, 1);
    check("t1_start_hi", {31'd0, conv_start}, 1);
    tick(1);
    check("t1_start_lo", {31'd0, conv_start}, 0);
    shift_bits(15, bits);
    check("t1_bits", {17'd0, bits}, {17'd0, 3'b000, 8'hA5, 4'b0000});
    check("t1_so_end", {31'd0, adc_so}, 0);
    check("t1_done", n_done - b_done, 1);
    check("t1_count", {16'd0, frame_count}, 1);
    check("t1_oe_done", {31'd0, adc_so_oe}, 1);
    adc_cs = 1'b1;
    tick(2);
    check("t1_oe_rel2", {31'd0, adc_so_oe}, 1);
    tick(1);
    check("t1_oe_rel3", {31'd0, adc_so_oe}, 0);
    check("t1_start_n", n_start - b_start, 1);
    tick(2);

    // 2: aborted frame then clean 3C frame
    snap();
    start_frame(8'h5A);
    shift_bits(6, bits);
    adc_cs = 1'b1;
    tick(4);
    check("t2_err", n_err - b_err, 1);
    check("t2_count", {16'd0, frame_count}, 1);
    check("t2_oe", {31'd0, adc_so_oe}, 0);
    check("t2_so", {31'd0, adc_so}, 0);
    start_frame(8'h3C);
    shift_bits(15, bits);
    check("t2_bits", {17'd0, bits}, {17'd0, 3'b000, 8'h3C, 4'b0000});
    check("t2_count2", {16'd0, frame_count}, 2);
    check("t2_done", n_done - b_done, 1);
    adc_cs = 1'b1;
    tick(4);

    // 3: sample_in changes right after capture
    sample_in = 8'hFF; adc_cs = 1'b0;
    tick(4);
    sample_in = 8'h00;
    shift_bits(15, bits);
    check("t3_bits", {17'd0, bits}, {17'd0, 3'b000, 8'hFF, 4'b0000});
    adc_cs = 1'b1;
    tick(4);

    // 5: cs release coincident with 15th fall
    snap();
    start_frame(8'h81);
    shift_bits(14, bits);
    check("t5_bits", {17'd0, bits}, {17'd0, 3'b000, 8'h81, 4'b0000});
    adc_clk = 1'b0; adc_cs = 1'b1;
    tick(5);
    adc_clk = 1'b1;
    tick(4);
    check("t5_err", n_err - b_err, 1);
    check("t5_done", n_done - b_done, 0);
    check("t5_count", {16'd0, frame_count}, 3);
    check("t5_oe", {31'd0, adc_so_oe}, 0);

    // 6: counter wrap and extra falls in DONE
    force dut.frame_count = 16'hFFFF;
    tick(1);
    release dut.frame_count;
    tick(1);
    snap();
    start_frame(8'h00);
    shift_bits(15, bits);
    check("t6_bits", {17'd0, bits}, 0);
    check("t6_wrap", {16'd0, frame_count}, 0);
    for (int k = 0; k < 20; k++) begin
      adc_clk = 1'b0; tick(4);
      adc_clk = 1'b1; tick(4);
      check("t6_done_so", {31'd0, adc_so}, 0);
    end
    check("t6_done_n", n_done - b_done, 1);
    check("t6_count2", {16'd0, frame_count}, 0);
    adc_cs = 1'b1;
    tick(4);

    // 4: reset at bit 7, then cs held low across release
    start_frame(8'hFF);
    shift_bits(7, bits);
    check("t4_pre_bits", {24'd0, bits[7:0]}, 32'h1F);
    check("t4_pre_so", {31'd0, adc_so}, 1);
    reset = 1'b1;
    #1;
    check("t4_rst_so", {31'd0, adc_so}, 0);
    check("t4_rst_oe", {31'd0, adc_so_oe}, 0);
    tick(2);
    reset = 1'b0;
    snap();
    tick(10);
    check("t4_no_start", n_start - b_start, 0);
    check("t4_idle_oe", {31'd0, adc_so_oe}, 0);
    adc_cs = 1'b1;
    tick(4);
    start_frame(8'h96);
    check("t4_start", n_start - b_start, 1);
    check("t4_oe", {31'd0, adc_so_oe}, 1);
    shift_bits(15, bits);
    check("t4_bits", {17'd0, bits}, {17'd0, 3'b000, 8'h96, 4'b0000});
    check("t4_count", {16'd0, frame_count}, 1);
    adc_cs = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
